// File: rtl/synth_param_pkg.sv
// Shared types and constants for the synth parameter write path:
// bank numbers, sequencer FSM states and the bank legality check.
package synth_param_pkg;

    localparam int unsigned ID_W = 3;

    localparam logic [2:0] BANK_ENV = 3'd0;
    localparam logic [2:0] BANK_OSC = 3'd1;
    localparam logic [2:0] BANK_M1  = 3'd2;
    localparam logic [2:0] BANK_M2  = 3'd3;
    localparam logic [2:0] BANK_COM = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        RECOVER,
        DROP
    } state_e;

    // Banks 4, 6 and 7 have no decoder target.
    function automatic logic bank_is_valid(input logic [2:0] bank);
        return (bank == BANK_ENV) || (bank == BANK_OSC) || (bank == BANK_M1) ||
               (bank == BANK_M2)  || (bank == BANK_COM);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant searching upward from a registered
// start pointer; the pointer moves past the winner on each accept pulse.
module rr_arbiter
    import synth_param_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               accept_i,
    output logic               grant_valid_c,
    output logic [ID_W-1:0]    grant_id_c
);

    localparam int unsigned IDX_W = ID_W + 1;

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [7:0]       req_pad;
    logic [IDX_W-1:0] idx;

    // First requester at or after the pointer, wrapping at NUM_REQ.
    always_comb begin
        req_pad       = 8'(req_i);
        grant_valid_c = 1'b0;
        grant_id_c    = '0;
        idx           = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            idx = {1'b0, ptr_q} + IDX_W'(i);
            if (idx >= IDX_W'(NUM_REQ)) begin
                idx = idx - IDX_W'(NUM_REQ);
            end
            if (!grant_valid_c && req_pad[idx[ID_W-1:0]]) begin
                grant_valid_c = 1'b1;
                grant_id_c    = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept_i) begin
            ptr_d = (grant_id_c == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_c + ID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/param_write_sequencer.sv
// Arbitrates requester parameter writes onto the synth parameter bus with a
// setup / strobe / recovery sequence. BANK_CHECK_EN drops writes to unmapped banks.
module param_write_sequencer
    import synth_param_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned ADR_W       = 7,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned STROBE_CYC  = 2,
    parameter int unsigned RECOVER_CYC = 6
) (
    input  logic                      CLOCK_25,
    input  logic                      reset_reg_N,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [3*NUM_REQ-1:0]      req_bank,
    input  logic [ADR_W*NUM_REQ-1:0]  req_adr,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      busy,
    output logic [2:0]                grant_id,
    output logic [2:0]                dec_addr,
    output logic [ADR_W-1:0]          param_adr,
    output logic [DATA_W-1:0]         param_data,
    output logic                      data_ready,
    output logic                      bad_bank
);

    localparam int unsigned CNT_MAX = (STROBE_CYC > RECOVER_CYC) ? STROBE_CYC : RECOVER_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ID_W-1:0]     gid_q, gid_d;
    logic [2:0]          bank_q, bank_d;
    logic [ADR_W-1:0]    adr_q, adr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                dr_q, dr_d;
    logic                busy_q, busy_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;

    logic                grant_valid_c;
    logic [ID_W-1:0]     grant_id_c;
    logic                accept_c;
    logic [2:0]          sel_bank_c;
    logic [ADR_W-1:0]    sel_adr_c;
    logic [DATA_W-1:0]   sel_data_c;

    function automatic logic [NUM_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            oh[i] = (id == ID_W'(i));
        end
        return oh;
    endfunction

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .clk          (CLOCK_25),
        .rst_n        (reset_reg_N),
        .req_i        (req),
        .accept_i     (accept_c),
        .grant_valid_c(grant_valid_c),
        .grant_id_c   (grant_id_c)
    );

    // Payload of the current arbitration winner.
    always_comb begin
        sel_bank_c = '0;
        sel_adr_c  = '0;
        sel_data_c = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_id_c == ID_W'(i)) begin
                sel_bank_c = req_bank[3*i +: 3];
                sel_adr_c  = req_adr[ADR_W*i +: ADR_W];
                sel_data_c = req_data[DATA_W*i +: DATA_W];
            end
        end
    end

`ifdef BANK_CHECK_EN
    logic bad_q, bad_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gid_d    = gid_q;
        bank_d   = bank_q;
        adr_d    = adr_q;
        data_d   = data_q;
        dr_d     = 1'b0;
        ack_d    = '0;
        accept_c = 1'b0;
`ifdef BANK_CHECK_EN
        bad_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (grant_valid_c) begin
                    accept_c = 1'b1;
                    gid_d    = grant_id_c;
                    state_d  = SETUP;
                    cnt_d    = '0;
                    bank_d   = sel_bank_c;
                    adr_d    = sel_adr_c;
                    data_d   = sel_data_c;
`ifdef BANK_CHECK_EN
                    // Rejected bank: bus keeps its old payload, no strobe.
                    if (!bank_is_valid(sel_bank_c)) begin
                        state_d = DROP;
                        bank_d  = bank_q;
                        adr_d   = adr_q;
                        data_d  = data_q;
                        ack_d   = id_onehot(grant_id_c);
                        bad_d   = 1'b1;
                    end
`endif
                end
            end
            SETUP: begin
                state_d = STROBE;
                dr_d    = 1'b1;
                cnt_d   = CNT_W'(STROBE_CYC - 1);
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d = RECOVER;
                    ack_d   = id_onehot(gid_q);
                    cnt_d   = CNT_W'(RECOVER_CYC - 1);
                end else begin
                    dr_d  = 1'b1;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RECOVER: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef BANK_CHECK_EN
            DROP: begin
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gid_q   <= '0;
            bank_q  <= '0;
            adr_q   <= '0;
            data_q  <= '0;
            dr_q    <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gid_q   <= gid_d;
            bank_q  <= bank_d;
            adr_q   <= adr_d;
            data_q  <= data_d;
            dr_q    <= dr_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

`ifdef BANK_CHECK_EN
    always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            bad_q <= 1'b0;
        end else begin
            bad_q <= bad_d;
        end
    end
    assign bad_bank = bad_q;
`else
    assign bad_bank = 1'b0;
`endif

    assign ack        = ack_q;
    assign busy       = busy_q;
    assign grant_id   = gid_q;
    assign dec_addr   = bank_q;
    assign param_adr  = adr_q;
    assign param_data = data_q;
    assign data_ready = dr_q;

endmodule

// File: tb/tb_param_write_sequencer.sv
// Directed bench for param_write_sequencer: single write, contention, payload hold,
// mid-strobe reset, unmapped bank (with/without BANK_CHECK_EN) and withdrawn request.
module tb_param_write_sequencer;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned ADR_W   = 7;
    localparam int unsigned DATA_W  = 8;

    logic                      CLOCK_25;
    logic                      reset_reg_N;
    logic [NUM_REQ-1:0]        req;
    logic [3*NUM_REQ-1:0]      req_bank;
    logic [ADR_W*NUM_REQ-1:0]  req_adr;
    logic [DATA_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic                      busy;
    logic [2:0]                grant_id;
    logic [2:0]                dec_addr;
    logic [ADR_W-1:0]          param_adr;
    logic [DATA_W-1:0]         param_data;
    logic                      data_ready;
    logic                      bad_bank;

    int pass_cnt  = 0;
    int check_cnt = 0;

    param_write_sequencer #(
        .NUM_REQ    (NUM_REQ),
        .ADR_W      (ADR_W),
        .DATA_W     (DATA_W),
        .STROBE_CYC (2),
        .RECOVER_CYC(6)
    ) dut (
        .CLOCK_25   (CLOCK_25),
        .reset_reg_N(reset_reg_N),
        .req        (req),
        .req_bank   (req_bank),
        .req_adr    (req_adr),
        .req_data   (req_data),
        .ack        (ack),
        .busy       (busy),
        .grant_id   (grant_id),
        .dec_addr   (dec_addr),
        .param_adr  (param_adr),
        .param_data (param_data),
        .data_ready (data_ready),
        .bad_bank   (bad_bank)
    );

    initial CLOCK_25 = 1'b0;
    always #5 CLOCK_25 = ~CLOCK_25;

    task automatic step();
        @(posedge CLOCK_25);
        #1;
    endtask

    task automatic do_reset();
        reset_reg_N = 1'b0;
        req = '0;
        step();
        reset_reg_N = 1'b1;
        step();
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40 && busy; i++) step();
        check_cnt++;
        if (busy !== 1'b0) $display("FAIL %s_idle_timeout: busy=%b required 0", name, busy);
        else pass_cnt++;
    endtask

    task automatic wait_ack(input int idx, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            if (ack[idx]) begin
                seen = 1'b1;
                req[idx] = 1'b0;
            end
        end
        check_cnt++;
        if (seen !== 1'b1) $display("FAIL %s_ack_timeout: ack[%0d] never seen, required pulse", name, idx);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset_reg_N = 1'b0;
        req = '0; req_bank = '0; req_adr = '0; req_data = '0;
        #3;
        step();
        check_cnt++;
        if ({ack, busy, grant_id, dec_addr, param_adr, param_data, data_ready, bad_bank} !== '0)
            $display("FAIL reset_outputs: ack=%b busy=%b gid=%0d bank=%0d adr=%h data=%h dr=%b bad=%b required all 0",
                     ack, busy, grant_id, dec_addr, param_adr, param_data, data_ready, bad_bank);
        else pass_cnt++;
        reset_reg_N = 1'b1;
        step();
        check_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_idle: busy=%b required 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_single_write();
        logic exp_dr, exp_busy;
        logic [1:0] exp_ack;
        req_bank[2:0] = 3'd1; req_adr[6:0] = 7'h12; req_data[7:0] = 8'hA5;
        req[0] = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            step();
            exp_dr   = (cyc == 2 || cyc == 3);
            exp_ack  = (cyc == 4) ? 2'b01 : 2'b00;
            exp_busy = (cyc <= 9);
            check_cnt++;
            if (data_ready !== exp_dr) $display("FAIL single_dr cyc%0d: got %b required %b", cyc, data_ready, exp_dr);
            else pass_cnt++;
            check_cnt++;
            if (ack !== exp_ack) $display("FAIL single_ack cyc%0d: got %b required %b", cyc, ack, exp_ack);
            else pass_cnt++;
            check_cnt++;
            if (busy !== exp_busy) $display("FAIL single_busy cyc%0d: got %b required %b", cyc, busy, exp_busy);
            else pass_cnt++;
            if (cyc <= 9) begin
                check_cnt++;
                if ({grant_id, dec_addr, param_adr, param_data} !== {3'd0, 3'd1, 7'h12, 8'hA5})
                    $display("FAIL single_payload cyc%0d: gid=%0d bank=%0d adr=%h data=%h required 0/1/12/a5",
                             cyc, grant_id, dec_addr, param_adr, param_data);
                else pass_cnt++;
            end
            if (ack[0]) req[0] = 1'b0;
        end
    endtask

    task automatic test_contention();
        int rem [2];
        int rises, last_rise;
        logic prev_dr;
        logic [2:0] exp_id;
        logic [7:0] exp_data;
        do_reset();
        req_bank = {3'd2, 3'd0}; req_adr = {7'h21, 7'h10}; req_data = {8'h22, 8'h11};
        rem[0] = 3; rem[1] = 3;
        rises = 0; last_rise = 0; prev_dr = 1'b0;
        req = 2'b11;
        for (int cyc = 1; cyc <= 100 && !(req == 2'b00 && !busy); cyc++) begin
            step();
            if (data_ready && !prev_dr) begin
                exp_id   = 3'(rises % 2);
                exp_data = (rises % 2 == 1) ? 8'h22 : 8'h11;
                check_cnt++;
                if (grant_id !== exp_id) $display("FAIL cont_grant rise%0d: got %0d required %0d", rises, grant_id, exp_id);
                else pass_cnt++;
                check_cnt++;
                if (param_data !== exp_data) $display("FAIL cont_data rise%0d: got %h required %h", rises, param_data, exp_data);
                else pass_cnt++;
                if (rises > 0) begin
                    check_cnt++;
                    if (cyc - last_rise !== 10) $display("FAIL cont_gap rise%0d: got %0d required 10", rises, cyc - last_rise);
                    else pass_cnt++;
                end
                last_rise = cyc;
                rises++;
            end
            prev_dr = data_ready;
            for (int i = 0; i < 2; i++) begin
                if (ack[i]) begin
                    rem[i]--;
                    if (rem[i] == 0) req[i] = 1'b0;
                end
            end
        end
        check_cnt++;
        if (rises !== 6) $display("FAIL cont_count: got %0d strobes required 6", rises);
        else pass_cnt++;
        wait_idle("cont");
    endtask

    task automatic test_payload_hold();
        req_bank[2:0] = 3'd2; req_adr[6:0] = 7'h34; req_data[7:0] = 8'hA5;
        req[0] = 1'b1;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            step();
            check_cnt++;
            if (param_data !== 8'hA5) $display("FAIL hold_data cyc%0d: got %h required a5", cyc, param_data);
            else pass_cnt++;
            if (cyc == 2) req_data[7:0] = 8'h00;
            if (ack[0]) req[0] = 1'b0;
        end
        wait_idle("hold");
    endtask

    task automatic test_reset_mid_strobe();
        req_bank[2:0] = 3'd3; req_adr[6:0] = 7'h05; req_data[7:0] = 8'h5A;
        req[0] = 1'b1;
        step();
        step();
        check_cnt++;
        if (data_ready !== 1'b1) $display("FAIL rst_pre_strobe: dr=%b required 1", data_ready);
        else pass_cnt++;
        #1 reset_reg_N = 1'b0;
        #1;
        check_cnt++;
        if ({data_ready, ack, busy, dec_addr} !== '0)
            $display("FAIL rst_async: dr=%b ack=%b busy=%b bank=%0d required all 0", data_ready, ack, busy, dec_addr);
        else pass_cnt++;
        step();
        reset_reg_N = 1'b1;
        step();
        check_cnt++;
        if ({busy, data_ready, dec_addr} !== {1'b1, 1'b0, 3'd3})
            $display("FAIL rst_restart_setup: busy=%b dr=%b bank=%0d required 1/0/3", busy, data_ready, dec_addr);
        else pass_cnt++;
        step();
        check_cnt++;
        if (data_ready !== 1'b1) $display("FAIL rst_restart_strobe: dr=%b required 1", data_ready);
        else pass_cnt++;
        wait_ack(0, "rst");
        wait_idle("rst");
    endtask

    task automatic test_bank6();
        req_bank[5:3] = 3'd6; req_adr[13:7] = 7'h7F; req_data[15:8] = 8'hC3;
        req[1] = 1'b1;
`ifdef BANK_CHECK_EN
        step();
        check_cnt++;
        if ({ack, bad_bank, data_ready} !== {2'b10, 1'b1, 1'b0})
            $display("FAIL bank6_drop: ack=%b bad=%b dr=%b required 10/1/0", ack, bad_bank, data_ready);
        else pass_cnt++;
        req[1] = 1'b0;
        step();
        check_cnt++;
        if ({ack, bad_bank, data_ready, busy} !== '0)
            $display("FAIL bank6_after: ack=%b bad=%b dr=%b busy=%b required all 0", ack, bad_bank, data_ready, busy);
        else pass_cnt++;
`else
        step();
        check_cnt++;
        if ({busy, grant_id} !== {1'b1, 3'd1}) $display("FAIL bank6_grant: busy=%b gid=%0d required 1/1", busy, grant_id);
        else pass_cnt++;
        step();
        check_cnt++;
        if ({data_ready, dec_addr, bad_bank} !== {1'b1, 3'd6, 1'b0})
            $display("FAIL bank6_strobe: dr=%b bank=%0d bad=%b required 1/6/0", data_ready, dec_addr, bad_bank);
        else pass_cnt++;
        wait_ack(1, "bank6");
        wait_idle("bank6");
`endif
    endtask

    task automatic test_withdraw();
        int rises, ack1_seen;
        logic prev_dr;
        rises = 0; ack1_seen = 0; prev_dr = 1'b0;
        req_bank = {3'd5, 3'd0}; req_adr = {7'h44, 7'h33}; req_data = {8'h99, 8'h66};
        req[0] = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            step();
            if (data_ready && !prev_dr) begin
                rises++;
                check_cnt++;
                if (grant_id !== 3'd0) $display("FAIL wd_grant: got %0d required 0", grant_id);
                else pass_cnt++;
            end
            prev_dr = data_ready;
            if (ack[1]) ack1_seen++;
            if (ack[0]) req[0] = 1'b0;
            if (cyc == 2) req[1] = 1'b1;
            if (cyc == 3) req[1] = 1'b0;
        end
        check_cnt++;
        if (rises !== 1) $display("FAIL wd_strobes: got %0d required 1", rises);
        else pass_cnt++;
        check_cnt++;
        if (ack1_seen !== 0) $display("FAIL wd_ack1: got %0d pulses required 0", ack1_seen);
        else pass_cnt++;
        check_cnt++;
        if (busy !== 1'b0) $display("FAIL wd_idle: busy=%b required 0", busy);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_payload_hold();
        test_reset_mid_strobe();
        test_bank6();
        test_withdraw();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
